// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default framing parameters
// used by the transmitter, receiver and baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERS_DEF     = 16;
  localparam int DATA_BITS_DEF = 8;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data; push is ignored when full
// and pop is ignored when empty, so the pointers can never over/underrun.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// MIDI-path UART transmitter: buffered bytes are serialised LSB-first as
// start/data/stop frames, advancing only on oversample ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERS      = OVERS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int STOP_BITS  = 1,
  parameter int INVERT     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        in_vld,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        in_rdy,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output uart_state_e                 state_dbg
);

  localparam int OS_W  = cnt_width(OVERS);
  localparam int BIT_W = cnt_width(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             INV       = (INVERT != 0);
  localparam logic             IDLE_LVL  = 1'b1 ^ INV;
  localparam logic             START_LVL = 1'b0 ^ INV;

  uart_state_e          state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (in_vld),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d     = IDLE_LVL;
        os_cnt_d = '0;
        if (tick && !fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          tx_d     = START_LVL;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            bit_idx_d = '0;
            tx_d      = shreg_q[0] ^ INV;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (bit_idx_q == BIT_LAST) begin
              tx_d       = IDLE_LVL;
              stop_idx_d = 1'b0;
              state_d    = ST_STOP;
            end else begin
              shreg_d   = shreg_q >> 1;
              tx_d      = shreg_q[1] ^ INV;
              bit_idx_d = bit_idx_q + BIT_W'(1);
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (stop_idx_q != STOP_LAST) begin
              stop_idx_d = 1'b1;
            end else begin
              done_d = 1'b1;
              // Chain straight into the next frame so queued bytes leave no idle gap.
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shreg_d  = fifo_rdata;
                tx_d     = START_LVL;
                state_d  = ST_START;
              end else begin
                tx_d    = IDLE_LVL;
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      default: begin
        tx_d     = IDLE_LVL;
        os_cnt_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      tx_q       <= IDLE_LVL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign in_rdy    = ~fifo_full;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default 8N1 instance and an inverted two-stop-bit
// instance, each checked every cycle against a tick-position frame model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int OV    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tick;
  logic        vld [2];
  logic [7:0]  dat [2];
  logic        rdy [2], txl [2], busy [2], done [2];
  logic [2:0]  cnt [2];
  uart_state_e st  [2];
  int          tick_mode, phase;

  uart_tx #(.STOP_BITS(1), .INVERT(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .in_vld(vld[0]), .in_data(dat[0]),
    .in_rdy(rdy[0]), .tx(txl[0]), .busy(busy[0]), .tx_done(done[0]),
    .fifo_cnt(cnt[0]), .state_dbg(st[0]));

  uart_tx #(.STOP_BITS(2), .INVERT(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .in_vld(vld[1]), .in_data(dat[1]),
    .in_rdy(rdy[1]), .tx(txl[1]), .busy(busy[1]), .tx_done(done[1]),
    .fifo_cnt(cnt[1]), .state_dbg(st[1]));

  // Tick pattern: 0 every 4th clk, 1 every clk, 2 every 2nd clk, 3 random gaps.
  initial begin
    tick = 1'b0; phase = 0;
    forever begin
      @(posedge clk); #1;
      case (tick_mode)
        0:       tick = (phase % 4 == 0);
        1:       tick = 1'b1;
        2:       tick = (phase % 2 == 0);
        default: tick = ($urandom_range(0, 2) == 0);
      endcase
      phase++;
    end
  end

  // ---------------- counters and check ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  logic [7:0] exp_q0[$], exp_q1[$];
  logic [7:0] mq0[$], mq1[$];

  function automatic int sb_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction
  function automatic logic [7:0] sb_pop(input int k);
    return (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction
  function automatic void sb_push(input int k, input logic [7:0] v);
    if (k == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction
  function automatic void sb_clear(input int k);
    if (k == 0) exp_q0.delete(); else exp_q1.delete();
  endfunction
  function automatic int mq_size(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction
  function automatic logic [7:0] mq_pop(input int k);
    return (k == 0) ? mq0.pop_front() : mq1.pop_front();
  endfunction
  function automatic void mq_push(input int k, input logic [7:0] v);
    if (k == 0) mq0.push_back(v); else mq1.push_back(v);
  endfunction

  function automatic logic inv_of(input int k);
    return (k == 1);
  endfunction
  function automatic int frame_ticks(input int k);
    return (1 + 8 + ((k == 0) ? 1 : 2)) * OV;
  endfunction

  // ---------------- model + decoder state ----------------
  bit          m_valid = 1'b0;
  bit          m_active [2];
  int          m_pos    [2];
  logic [15:0] m_fr     [2];
  bit          m_done   [2];
  bit          d_hunt   [2];
  int          d_off    [2];
  logic [7:0]  d_sh     [2];
  int          tcount [2], start_t [2], last_len [2], last_gap [2], last_done_t [2];
  int          done_cnt [2], rx_cnt [2];
  logic [7:0]  last_rx [2];
  logic        prev_tx [2];
  logic        tick_prev = 1'b0, rst_prev = 1'b1;

  // Model: a frame is a bit vector {stop.., data, start}; after k ticks into
  // the frame the line carries bit k/OVERS; done fires at the frame's length.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_pos[k] = 0; m_done[k] = 0; m_fr[k] = '1;
      d_hunt[k] = 1; d_off[k] = 0; d_sh[k] = '0; tcount[k] = 0; start_t[k] = 0;
      last_len[k] = 0; last_gap[k] = 0; last_done_t[k] = 0; done_cnt[k] = 0;
      rx_cnt[k] = 0; last_rx[k] = '0; prev_tx[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic inv, line, e_tx;
        int   sz;
        inv = inv_of(k);
        sz  = mq_size(k);
        if (m_valid) begin
          e_tx = (m_active[k] ? m_fr[k][m_pos[k] / OV] : 1'b1) ^ inv;
          check($sformatf("tx%0d", k), txl[k], e_tx);
          check($sformatf("busy%0d", k), busy[k], (m_active[k] || sz != 0));
          check($sformatf("in_rdy%0d", k), rdy[k], (sz != DEPTH));
          check($sformatf("fifo_cnt%0d", k), cnt[k], sz);
          check($sformatf("tx_done%0d", k), done[k], m_done[k]);
          if (!tick_prev && !rst_prev)
            check($sformatf("tx_hold%0d", k), txl[k], prev_tx[k]);
        end
        prev_tx[k] = txl[k];

        // Line decoder: mid-bit sampling, independent of the model.
        if (rst_prev) begin
          d_hunt[k] = 1;
        end else begin
          if (tick_prev) tcount[k]++;
          if (done[k]) begin
            done_cnt[k]++;
            last_len[k]    = tcount[k] - start_t[k];
            last_gap[k]    = tcount[k] - last_done_t[k];
            last_done_t[k] = tcount[k];
          end
          line = txl[k] ^ inv;
          if (d_hunt[k]) begin
            if (line == 1'b0) begin
              d_hunt[k] = 0; d_off[k] = 0; start_t[k] = tcount[k];
            end
          end else if (tick_prev) begin
            d_off[k]++;
            if (d_off[k] == 8) begin
              check($sformatf("start_bit%0d", k), line, 0);
            end else if (d_off[k] >= 24 && d_off[k] <= 136 && d_off[k] % 16 == 8) begin
              d_sh[k] = {line, d_sh[k][7:1]};
            end else if (d_off[k] == 152) begin
              check($sformatf("stop_bit%0d", k), line, 1);
              rx_cnt[k]++;
              last_rx[k] = d_sh[k];
              if (sb_size(k) == 0) begin
                vectors++; miscompares++;
                $display("FAIL byte%0d: got %0h, want none queued @%0t", k, d_sh[k], $time);
              end else begin
                check($sformatf("byte%0d", k), d_sh[k], sb_pop(k));
              end
              d_hunt[k] = 1;
            end
          end
        end

        // Advance the model across the coming posedge.
        if (rst) begin
          if (k == 0) mq0.delete(); else mq1.delete();
          m_active[k] = 0; m_pos[k] = 0; m_done[k] = 0;
          m_valid = 1'b1;
        end else if (m_valid) begin
          m_done[k] = 0;
          if (tick) begin
            if (m_active[k]) begin
              m_pos[k]++;
              if (m_pos[k] == frame_ticks(k)) begin
                m_done[k] = 1; m_active[k] = 0;
              end
            end
            if (!m_active[k] && sz != 0) begin
              logic [15:0] f;
              f = '1; f[8:1] = mq_pop(k); f[0] = 1'b0;
              m_fr[k] = f; m_active[k] = 1; m_pos[k] = 0;
            end
          end
          if (vld[k] && sz < DEPTH) mq_push(k, dat[k]);
        end
      end
      tick_prev = tick;
      rst_prev  = rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int k, input logic [7:0] b, output int stalls);
    logic acc;
    acc = 1'b0; stalls = 0;
    vld[k] = 1'b1; dat[k] = b;
    while (!acc && stalls < 40000) begin
      @(negedge clk);
      acc = rdy[k];
      if (!acc) check($sformatf("full_cnt%0d", k), cnt[k], DEPTH);
      @(posedge clk); #1;
      if (!acc) stalls++;
    end
    vld[k] = 1'b0;
    if (acc) sb_push(k, b);
    else check($sformatf("push_timeout%0d", k), 0, 1);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[k] && n < 40000) begin
      @(negedge clk); n++;
    end
    check($sformatf("idle_timeout%0d", k), (n < 40000), 1);
    @(posedge clk); #1;
    step(2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: run exceeded time limit @%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, tot, d0, d1, n;
    rst = 1'b1; tick_mode = 0;
    vld[0] = 0; vld[1] = 0; dat[0] = 0; dat[1] = 0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx0", txl[0], 1);
    check("rst_tx1", txl[1], 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rdy%0d", k), rdy[k], 1);
      check($sformatf("rst_busy%0d", k), busy[k], 0);
      check($sformatf("rst_cnt%0d", k), cnt[k], 0);
      check($sformatf("rst_done%0d", k), done[k], 0);
    end
    @(posedge clk); #1;

    // Single 0x90 frame.
    d0 = done_cnt[0];
    push(0, 8'h90, s);
    wait_idle(0);
    check("t1_byte", last_rx[0], 8'h90);
    check("t1_done_pulses", done_cnt[0] - d0, 1);
    check("t1_frame_ticks", last_len[0], 160);

    // Back-to-back MIDI message, ticks every 2 clks.
    tick_mode = 2; d0 = done_cnt[0];
    push(0, 8'h90, s); check("b2b_rdy_a", s, 0);
    push(0, 8'h3C, s); check("b2b_rdy_b", s, 0);
    push(0, 8'h64, s); check("b2b_rdy_c", s, 0);
    wait_idle(0);
    check("b2b_done_pulses", done_cnt[0] - d0, 3);
    check("b2b_done_gap", last_gap[0], 160);
    check("b2b_last_byte", last_rx[0], 8'h64);

    // Overfill with random bytes and random tick gaps.
    tick_mode = 3; tot = 0;
    for (int i = 0; i < 6; i++) begin
      push(0, 8'($urandom), s); tot += s;
    end
    wait_idle(0);
    check("ovf_stalled", (tot > 0), 1);
    check("ovf_all_sent", sb_size(0), 0);

    // Reset 70 ticks into a frame with two bytes queued.
    tick_mode = 0;
    push(0, 8'h11, s); push(0, 8'h22, s); push(0, 8'h33, s);
    n = 0;
    while (!(m_active[0] && m_pos[0] >= 70) && n < 5000) begin step(1); n++; end
    check("mid_wait", (n < 5000), 1);
    check("mid_queued", cnt[0], 2);
    d0 = done_cnt[0];
    rst = 1'b1; step(1); rst = 1'b0;
    sb_clear(0);
    @(negedge clk);
    check("mid_rst_tx", txl[0], 1);
    check("mid_rst_cnt", cnt[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_done", done[0], 0);
    @(posedge clk); #1;
    step(100);
    check("mid_no_done", done_cnt[0], d0);
    push(0, 8'hF8, s);
    wait_idle(0);
    check("mid_after_byte", last_rx[0], 8'hF8);
    check("mid_after_ticks", last_len[0], 160);

    // Inverted line, two stop bits, ticks on every clk.
    tick_mode = 1; d1 = done_cnt[1];
    check("inv_idle_line", txl[1], 0);
    push(1, 8'hFE, s);
    wait_idle(1);
    check("inv_byte", last_rx[1], 8'hFE);
    check("inv_frame_ticks", last_len[1], 176);
    check("inv_done_pulses", done_cnt[1] - d1, 1);
    tick_mode = 2;
    for (int i = 0; i < 3; i++) push(1, 8'($urandom), s);
    wait_idle(1);
    check("inv_b2b_gap", last_gap[1], 176);

    // Random traffic on both instances with irregular ticks.
    tick_mode = 3; d0 = done_cnt[0]; d1 = done_cnt[1];
    fork
      begin
        int s0;
        for (int i = 0; i < 8; i++) begin
          push(0, 8'($urandom), s0);
          step($urandom_range(0, 40));
        end
      end
      begin
        int s1;
        for (int i = 0; i < 8; i++) begin
          push(1, 8'($urandom), s1);
          step($urandom_range(0, 40));
        end
      end
    join
    wait_idle(0);
    wait_idle(1);
    check("rnd_done0", done_cnt[0] - d0, 8);
    check("rnd_done1", done_cnt[1] - d1, 8);
    check("rnd_sb0_empty", sb_size(0), 0);
    check("rnd_sb1_empty", sb_size(1), 0);

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter for the MIDI output path (31250 baud, 8N1): serialises bytes LSB-first onto the tx pin.
- Shares the 16x oversample tick from baud_gen with the receiver.
- Contains a small input FIFO so a 3-byte MIDI message (e.g. 0x90 0x3C 0x64) can be pushed back-to-back without stalling the producer.
- Sits between the MIDI message formatter (upstream, valid/ready) and the output pin driver/opto stage.

Parameters:
- OVERS, 16, ticks per bit; every bit (start, data, stop) lasts exactly OVERS ticks.
- DATA_BITS, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- INVERT, 0, 1 = invert the tx output polarity (idle low).
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  synchronous reset, active-high
- tick  input  1  oversample tick from baud_gen, 1-clk pulse, OVERS per bit
- in_vld  input  1  upstream byte valid
- in_data  input  8  byte to send
- in_rdy  output  1  FIFO can accept; a byte is transferred on a cycle with in_vld & in_rdy
- tx  output  1  serial line, registered
- busy  output  1  frame in progress or FIFO non-empty
- tx_done  output  1  1-clk pulse at the end of each frame's last stop bit
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, rst=1):
  - state = IDLE; FIFO flushed (fifo_cnt = 0).
  - tx = idle level (1 when INVERT=0, 0 when INVERT=1).
  - in_rdy = 1, busy = 0, tx_done = 0.
- Reset mid-frame: the frame is aborted and tx is at the idle level on the cycle after rst. No tx_done is produced. All queued bytes are lost.
- FIFO (clk domain, not tick-gated):
  - Push when in_vld & in_rdy.
  - in_rdy = (fifo_cnt != FIFO_DEPTH), from registered state only, so there is no combinational path from in_vld.
  - Push and pop in the same cycle leaves fifo_cnt unchanged.
  - When full, in_rdy=0 and in_data is ignored. No overflow is possible.
  - Pop requires fifo_cnt != 0. A byte pushed in cycle N is poppable from cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: all state advances happen only on cycles with tick=1. Between ticks everything holds.
  - IDLE: tx = idle level. On a tick with FIFO non-empty:
    - pop the byte into the shift register; os_cnt=0;
    - tx <= start level (0 ^ INVERT); go to START.
  - START: os_cnt increments each tick. At os_cnt==OVERS-1:
    - os_cnt=0, bit_idx=0;
    - tx <= shreg[0]; go to DATA.
  - DATA: at os_cnt==OVERS-1:
    - if bit_idx==DATA_BITS-1: tx <= stop level (1 ^ INVERT), stop_idx=0, go to STOP;
    - else: shift right, tx <= next bit, bit_idx+1.
  - STOP: at os_cnt==OVERS-1:
    - if stop_idx < STOP_BITS-1: stop_idx+1, stay in STOP;
    - else: pulse tx_done; then, on the same tick, if the FIFO is non-empty pop and go to START (tx <= start level, no idle gap); otherwise go to IDLE.
- Latency and timing:
  - Byte pushed into an empty idle block: start bit begins on the first tick at least 1 clk after the push.
  - Frame length = (1 + DATA_BITS + STOP_BITS) * OVERS ticks exactly.
- busy = (state != IDLE) | (fifo_cnt != 0).
- Widths:
  - os_cnt is $clog2(OVERS) bits.
  - bit_idx is $clog2(DATA_BITS) bits; OVERS=16 and DATA_BITS=8 must not overflow their counters.
- If tick is high on two consecutive clocks, each pulse counts as one tick.
- Unused encodings of the state register recover to IDLE with tx at the idle level.

Decomposition:
- Shared package (uart_pkg): state encodings (ST_IDLE, ST_START, ST_DATA, ST_STOP) and the defaults for OVERS and DATA_BITS. These are also used by the receiver and baud_gen.
- One sub-module: sync_fifo with parameters WIDTH=8 and DEPTH=FIFO_DEPTH, and push/pop/full/empty/count. It is reusable on the receive side later.
- The serialiser FSM stays in uart_tx.

Test Plan:
- Single byte 0x90, OVERS=16, idle block: tx = 0 for 16 ticks, then bits 0,0,0,0,1,0,0,1 at 16 ticks each, then 1 for 16 ticks. tx_done pulses once, 160 ticks after the start edge. busy falls with IDLE.
- Back-to-back 0x90, 0x3C, 0x64 pushed on 3 consecutive clks: all accepted (in_rdy stays 1). Three frames run with no idle gap: the stop of frame 1 is followed directly by the start of frame 2. 3 tx_done pulses, 160 ticks apart.
- Overfill with FIFO_DEPTH=4: push 6 bytes continuously while the first frame is active. in_rdy drops when fifo_cnt=4 and the bench holds in_vld. All 6 bytes appear on tx in order, none lost or duplicated.
- rst asserted at tick 70 of a frame with 2 bytes queued: the next clk has tx=1, fifo_cnt=0, busy=0, and no tx_done. A new byte 0xF8 afterwards transmits as a clean full frame.
- STOP_BITS=2 and INVERT=1, byte 0xFE: the idle line is 0. Start is 1 for 16 ticks, then the inverted data bits 1,0,0,0,0,0,0,0, then 0 for 32 ticks. A loopback into uart_rx (INVERT=1) yields vld with data=0xFE and framing_err=0.
- Tick spacing stress (ticks every 2 clks, and irregular gaps): bit widths stay exactly 16 ticks, and tx changes only on tick cycles.
